// File: rtl/pht_update_scheduler.sv
// PHT write-port scheduler: saturating counter updates, per-bank arbitration,
// deferred-update FIFO for bank conflicts, and the table init sweep.
module pht_update_scheduler #(
    parameter int ENTRY_NUM  = 1024,
    parameter int ENTRY_BIT  = 2,
    parameter int REQ_NUM    = 2,
    parameter int BANK_NUM   = 2,
    parameter int QUEUE_SIZE = 8,
    localparam int IDX_W  = $clog2(ENTRY_NUM),
    localparam int BANK_W = $clog2(BANK_NUM),
    localparam int ROW_W  = IDX_W - BANK_W,
    localparam int QP_W   = $clog2(QUEUE_SIZE)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 initStart,
    input  logic [REQ_NUM-1:0]   reqValid,
    input  logic [IDX_W-1:0]     reqAddr [REQ_NUM],
    input  logic [REQ_NUM-1:0]   reqTaken,
    input  logic [ENTRY_BIT-1:0] reqPrev [REQ_NUM],
    output logic [BANK_NUM-1:0]  wrEn,
    output logic [ROW_W-1:0]     wrRow [BANK_NUM],
    output logic [ENTRY_BIT-1:0] wrVal [BANK_NUM],
    output logic                 initBusy,
    output logic [QP_W:0]        qCount,
    output logic                 qOverflow,
    output logic [7:0]           dropCnt
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ENTRY_BIT-1:0] MAX      = '1;
    localparam logic [ENTRY_BIT-1:0] INIT_VAL = ENTRY_BIT'(2 ** (ENTRY_BIT - 1));
    localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(ENTRY_NUM / BANK_NUM - 1);
    localparam logic [QP_W:0]        Q_DEPTH  = (QP_W + 1)'(QUEUE_SIZE);

    logic [0:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [QP_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [QP_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [QP_W:0]    cnt_q, cnt_d;
    logic [7:0]       drop_q, drop_d;

    logic [BANK_W-1:0]    q_bank_q [QUEUE_SIZE];
    logic [BANK_W-1:0]    q_bank_d [QUEUE_SIZE];
    logic [ROW_W-1:0]     q_row_q  [QUEUE_SIZE];
    logic [ROW_W-1:0]     q_row_d  [QUEUE_SIZE];
    logic [ENTRY_BIT-1:0] q_val_q  [QUEUE_SIZE];
    logic [ENTRY_BIT-1:0] q_val_d  [QUEUE_SIZE];

    logic [BANK_W-1:0]    req_bank [REQ_NUM];
    logic [ROW_W-1:0]     req_row  [REQ_NUM];
    logic [ENTRY_BIT-1:0] req_val  [REQ_NUM];

    logic [BANK_NUM-1:0] claimed;
    logic [BANK_W-1:0]   head_bank;
    logic                pop;
    logic [QP_W:0]       free_slots;
    logic [QP_W:0]       n_push;
    logic [7:0]          n_drop;
    logic [8:0]          drop_sum;
    logic [QP_W-1:0]     slot;

    // Saturating counter step, computed for every request regardless of grant
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            req_bank[i] = reqAddr[i][BANK_W-1:0];
            req_row[i]  = reqAddr[i][IDX_W-1:BANK_W];
            if (reqTaken[i]) begin
                req_val[i] = (reqPrev[i] == MAX) ? MAX
                           : reqPrev[i] + ENTRY_BIT'(1);
            end else begin
                req_val[i] = (reqPrev[i] == '0) ? '0
                           : reqPrev[i] - ENTRY_BIT'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        q_bank_d   = q_bank_q;
        q_row_d    = q_row_q;
        q_val_d    = q_val_q;
        wrEn       = '0;
        qOverflow  = 1'b0;
        claimed    = '0;
        head_bank  = '0;
        pop        = 1'b0;
        free_slots = '0;
        n_push     = '0;
        n_drop     = '0;
        drop_sum   = '0;
        slot       = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            wrRow[b] = '0;
            wrVal[b] = '0;
        end

        case (state_q)
            ST_INIT: begin
                wrEn = '1;
                for (int b = 0; b < BANK_NUM; b++) begin
                    wrRow[b] = row_q;
                    wrVal[b] = INIT_VAL;
                end
                row_d = row_q + ROW_W'(1);
                if (row_q == ROW_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (initStart) begin
                    state_d  = ST_INIT;
                    row_d    = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                end else begin
                    if (cnt_q != '0) begin
                        head_bank           = q_bank_q[rd_ptr_q];
                        wrEn[head_bank]     = 1'b1;
                        wrRow[head_bank]    = q_row_q[rd_ptr_q];
                        wrVal[head_bank]    = q_val_q[rd_ptr_q];
                        claimed[head_bank]  = 1'b1;
                        pop                 = 1'b1;
                    end
                    // A popped head frees its slot for this cycle's pushes
                    free_slots = Q_DEPTH - cnt_q + (QP_W + 1)'(pop);
                    for (int i = 0; i < REQ_NUM; i++) begin
                        if (reqValid[i]) begin
                            if (!claimed[req_bank[i]]) begin
                                claimed[req_bank[i]] = 1'b1;
                                wrEn[req_bank[i]]    = 1'b1;
                                wrRow[req_bank[i]]   = req_row[i];
                                wrVal[req_bank[i]]   = req_val[i];
                            end else if (n_push < free_slots) begin
                                slot          = wr_ptr_q + n_push[QP_W-1:0];
                                q_bank_d[slot] = req_bank[i];
                                q_row_d[slot]  = req_row[i];
                                q_val_d[slot]  = req_val[i];
                                n_push        = n_push + (QP_W + 1)'(1);
                            end else begin
                                n_drop = n_drop + 8'd1;
                            end
                        end
                    end
                    qOverflow = (n_drop != '0);
                    drop_sum  = {1'b0, drop_q} + {1'b0, n_drop};
                    drop_d    = drop_sum[8] ? 8'hff : drop_sum[7:0];
                    rd_ptr_d  = rd_ptr_q + QP_W'(pop);
                    wr_ptr_d  = wr_ptr_q + n_push[QP_W-1:0];
                    cnt_d     = cnt_q - (QP_W + 1)'(pop) + n_push;
                end
            end
            default: begin
                state_d = ST_INIT;
                row_d   = '0;
            end
        endcase

        if (!rstN) begin
            wrEn = '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= ST_INIT;
            row_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        q_bank_q <= q_bank_d;
        q_row_q  <= q_row_d;
        q_val_q  <= q_val_d;
    end

    assign initBusy = (state_q == ST_INIT);
    assign qCount   = cnt_q;
    assign dropCnt  = drop_q;

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Bench for pht_update_scheduler: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_pht_update_scheduler;

    localparam int ROWS = 512;
    localparam int QSZ  = 8;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       initStart = 1'b0;
    logic [1:0] reqValid = '0;
    logic [9:0] reqAddr [2];
    logic [1:0] reqTaken = '0;
    logic [1:0] reqPrev [2];
    logic [1:0] wrEn;
    logic [8:0] wrRow [2];
    logic [1:0] wrVal [2];
    logic       initBusy;
    logic [3:0] qCount;
    logic       qOverflow;
    logic [7:0] dropCnt;

    int vec = 0;
    int errs = 0;

    pht_update_scheduler dut (
        .clk(clk), .rstN(rstN), .initStart(initStart),
        .reqValid(reqValid), .reqAddr(reqAddr),
        .reqTaken(reqTaken), .reqPrev(reqPrev),
        .wrEn(wrEn), .wrRow(wrRow), .wrVal(wrVal),
        .initBusy(initBusy), .qCount(qCount),
        .qOverflow(qOverflow), .dropCnt(dropCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bank;
        int row;
        int val;
    } upd_t;

    upd_t mq[$];
    int   m_init = 1;
    int   m_row = 0;
    int   m_drop = 0;

    bit   e_en [2];
    int   e_row [2];
    int   e_val [2];
    bit   e_ovf;
    bit   e_pop;
    upd_t e_push[$];
    int   e_ndrop;

    task automatic m_comb();
        upd_t cand[$];
        bit   claimed [2];
        int   b, v, fr;
        upd_t u;
        e_ovf = 0;
        e_pop = 0;
        e_ndrop = 0;
        e_push.delete();
        for (int k = 0; k < 2; k++) begin
            e_en[k] = 0; e_row[k] = 0; e_val[k] = 0; claimed[k] = 0;
        end
        if (rstN !== 1'b1) return;
        if (m_init != 0) begin
            for (int k = 0; k < 2; k++) begin
                e_en[k] = 1; e_row[k] = m_row; e_val[k] = 2;
            end
            return;
        end
        if (initStart) return;
        if (mq.size() > 0) begin
            b = mq[0].bank;
            e_en[b] = 1; e_row[b] = mq[0].row; e_val[b] = mq[0].val;
            claimed[b] = 1;
            e_pop = 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (reqValid[i]) begin
                v = int'(reqPrev[i]) + (reqTaken[i] ? 1 : -1);
                if (v > 3) v = 3;
                if (v < 0) v = 0;
                u.bank = int'(reqAddr[i]) % 2;
                u.row  = int'(reqAddr[i]) / 2;
                u.val  = v;
                if (!claimed[u.bank]) begin
                    claimed[u.bank] = 1;
                    e_en[u.bank] = 1; e_row[u.bank] = u.row; e_val[u.bank] = u.val;
                end else begin
                    cand.push_back(u);
                end
            end
        end
        fr = QSZ - mq.size() + (e_pop ? 1 : 0);
        foreach (cand[k]) begin
            if (e_push.size() < fr) e_push.push_back(cand[k]);
            else e_ndrop++;
        end
        e_ovf = (e_ndrop > 0);
    endtask

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mq.delete();
            m_init = 1;
            m_row = 0;
            m_drop = 0;
        end else begin
            m_comb();
            if (m_init != 0) begin
                if (m_row == ROWS - 1) m_init = 0;
                m_row = (m_row + 1) % ROWS;
            end else if (initStart) begin
                mq.delete();
                m_init = 1;
                m_row = 0;
            end else begin
                if (e_pop) void'(mq.pop_front());
                foreach (e_push[k]) mq.push_back(e_push[k]);
                m_drop += e_ndrop;
                if (m_drop > 255) m_drop = 255;
            end
        end
    end

    task automatic drive_idle();
        initStart = 1'b0;
        reqValid = '0;
        reqTaken = 2'($urandom);
        for (int i = 0; i < 2; i++) begin
            reqAddr[i] = 10'($urandom);
            reqPrev[i] = 2'($urandom);
        end
    endtask

    task automatic set_req(input int i, input int addr, input bit t, input int p);
        reqValid[i] = 1'b1;
        reqAddr[i]  = 10'(addr);
        reqTaken[i] = t;
        reqPrev[i]  = 2'(p);
    endtask

    task automatic test_reset();
        drive_idle();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vec++; if (wrEn !== 2'b00) begin errs++; $display("FAIL reset_wrEn got %b want 00", wrEn); end
        vec++; if (initBusy !== 1'b1) begin errs++; $display("FAIL reset_initBusy got %b want 1", initBusy); end
        vec++; if (qCount !== 4'd0) begin errs++; $display("FAIL reset_qCount got %0d want 0", qCount); end
        vec++; if (qOverflow !== 1'b0) begin errs++; $display("FAIL reset_qOverflow got %b want 0", qOverflow); end
        vec++; if (dropCnt !== 8'd0) begin errs++; $display("FAIL reset_dropCnt got %0d want 0", dropCnt); end
    endtask

    task automatic test_init_sweep();
        @(negedge clk);
        rstN = 1'b1;
        for (int c = 0; c < ROWS; c++) begin
            if (c > 0) @(negedge clk);
            initStart = 1'($urandom);
            reqValid = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                reqAddr[i] = 10'($urandom);
                reqPrev[i] = 2'($urandom);
            end
            #1;
            vec++;
            if (initBusy !== 1'b1 || wrEn !== 2'b11 || wrRow[0] !== 9'(c) || wrRow[1] !== 9'(c)
                || wrVal[0] !== 2'd2 || wrVal[1] !== 2'd2 || qCount !== 4'd0) begin
                errs++;
                $display("FAIL init_sweep cycle %0d: busy=%b en=%b rows=%0d/%0d vals=%0d/%0d q=%0d want busy=1 en=11 rows=%0d vals=2 q=0",
                         c, initBusy, wrEn, wrRow[0], wrRow[1], wrVal[0], wrVal[1], qCount, c);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        vec++;
        if (initBusy !== 1'b0 || wrEn !== 2'b00) begin
            errs++;
            $display("FAIL init_done busy=%b en=%b want busy=0 en=00", initBusy, wrEn);
        end
    endtask

    task automatic test_pair();
        @(negedge clk);
        drive_idle();
        set_req(0, 4, 1'b1, 1);
        set_req(1, 7, 1'b0, 0);
        #1;
        vec++;
        if (wrEn !== 2'b11 || wrRow[0] !== 9'd2 || wrVal[0] !== 2'd2 || wrRow[1] !== 9'd3 || wrVal[1] !== 2'd0) begin
            errs++;
            $display("FAIL pair en=%b b0=r%0d/v%0d b1=r%0d/v%0d want en=11 b0=r2/v2 b1=r3/v0",
                     wrEn, wrRow[0], wrVal[0], wrRow[1], wrVal[1]);
        end
        @(negedge clk);
        drive_idle();
        #1;
        vec++; if (qCount !== 4'd0) begin errs++; $display("FAIL pair_qCount got %0d want 0", qCount); end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        drive_idle();
        set_req(0, 6, 1'b1, 3);
        set_req(1, 10, 1'b1, 2);
        #1;
        vec++;
        if (wrEn !== 2'b01 || wrRow[0] !== 9'd3 || wrVal[0] !== 2'd3) begin
            errs++;
            $display("FAIL conflict_grant en=%b row=%0d val=%0d want en=01 row=3 val=3", wrEn, wrRow[0], wrVal[0]);
        end
        @(negedge clk);
        drive_idle();
        #1;
        vec++;
        if (qCount !== 4'd1 || wrEn !== 2'b01 || wrRow[0] !== 9'd5 || wrVal[0] !== 2'd3) begin
            errs++;
            $display("FAIL conflict_deferred q=%0d en=%b row=%0d val=%0d want q=1 en=01 row=5 val=3",
                     qCount, wrEn, wrRow[0], wrVal[0]);
        end
        @(negedge clk);
        #1;
        vec++;
        if (qCount !== 4'd0 || wrEn !== 2'b00) begin
            errs++;
            $display("FAIL conflict_drained q=%0d en=%b want q=0 en=00", qCount, wrEn);
        end
    endtask

    task automatic test_fill_overflow();
        int d0;
        int done;
        d0 = int'(dropCnt);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            drive_idle();
            for (int i = 0; i < 2; i++)
                set_req(i, 2 * $urandom_range(0, 511), 1'($urandom), $urandom_range(0, 3));
            #1;
            m_comb();
            vec++;
            if (qCount !== 4'((k - 1 < 8) ? k - 1 : 8)) begin
                errs++; $display("FAIL fill_qCount cycle %0d got %0d want %0d", k, qCount, (k - 1 < 8) ? k - 1 : 8);
            end
            vec++;
            if (qOverflow !== (k >= 9)) begin
                errs++; $display("FAIL fill_qOverflow cycle %0d got %b want %b", k, qOverflow, (k >= 9));
            end
            vec++;
            if (dropCnt !== 8'(d0 + ((k > 9) ? k - 9 : 0))) begin
                errs++; $display("FAIL fill_dropCnt cycle %0d got %0d want %0d", k, dropCnt, d0 + ((k > 9) ? k - 9 : 0));
            end
            vec++;
            if (wrEn[0] !== 1'b1 || wrRow[0] !== 9'(e_row[0]) || wrVal[0] !== 2'(e_val[0])) begin
                errs++;
                $display("FAIL fill_bank0 cycle %0d en=%b row=%0d val=%0d want en=1 row=%0d val=%0d",
                         k, wrEn[0], wrRow[0], wrVal[0], e_row[0], e_val[0]);
            end
        end
        done = 0;
        for (int n = 0; n < 20 && done == 0; n++) begin
            @(negedge clk);
            drive_idle();
            #1;
            m_comb();
            vec++;
            if (wrEn !== {e_en[1], e_en[0]} || (e_en[0] && (wrRow[0] !== 9'(e_row[0]) || wrVal[0] !== 2'(e_val[0])))) begin
                errs++;
                $display("FAIL drain_head en=%b row=%0d val=%0d want en=%b%b row=%0d val=%0d",
                         wrEn, wrRow[0], wrVal[0], e_en[1], e_en[0], e_row[0], e_val[0]);
            end
            if (qCount === 4'd0) done = 1;
        end
        vec++;
        if (done == 0) begin errs++; $display("FAIL drain_timeout qCount=%0d want 0 within 20 cycles", qCount); end
    endtask

    task automatic test_init_start();
        int d0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_idle();
            set_req(0, 2 * $urandom_range(0, 511), 1'($urandom), $urandom_range(0, 3));
            set_req(1, 2 * $urandom_range(0, 511), 1'($urandom), $urandom_range(0, 3));
        end
        @(negedge clk);
        drive_idle();
        #1;
        vec++; if (qCount !== 4'd5) begin errs++; $display("FAIL istart_setup qCount got %0d want 5", qCount); end
        d0 = int'(dropCnt);
        @(negedge clk);
        initStart = 1'b1;
        set_req(0, 3, 1'b1, 1);
        set_req(1, 8, 1'b0, 2);
        #1;
        vec++;
        if (wrEn !== 2'b00 || qOverflow !== 1'b0) begin
            errs++; $display("FAIL istart_same_cycle en=%b ovf=%b want en=00 ovf=0", wrEn, qOverflow);
        end
        @(negedge clk);
        drive_idle();
        #1;
        vec++;
        if (qCount !== 4'd0 || initBusy !== 1'b1 || wrEn !== 2'b11 || wrRow[0] !== 9'd0 || wrRow[1] !== 9'd0) begin
            errs++;
            $display("FAIL istart_next q=%0d busy=%b en=%b rows=%0d/%0d want q=0 busy=1 en=11 rows=0/0",
                     qCount, initBusy, wrEn, wrRow[0], wrRow[1]);
        end
        vec++;
        if (dropCnt !== 8'(d0)) begin errs++; $display("FAIL istart_dropCnt got %0d want %0d", dropCnt, d0); end
        repeat (ROWS) @(negedge clk);
        #1;
        vec++; if (initBusy !== 1'b0) begin errs++; $display("FAIL istart_sweep_end busy=%b want 0", initBusy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            initStart = (m_init == 0 && n > 150 && $urandom_range(0, 199) == 0);
            for (int i = 0; i < 2; i++) begin
                reqValid[i] = ($urandom_range(0, 3) != 0);
                reqAddr[i]  = 10'($urandom_range(0, 1023));
                if (n < 100) reqAddr[i][0] = 1'b0;
                reqTaken[i] = 1'($urandom);
                reqPrev[i]  = 2'($urandom);
            end
            #1;
            m_comb();
            vec++;
            if (initBusy !== (m_init != 0)) begin errs++; $display("FAIL rnd_initBusy cyc %0d got %b want %0d", n, initBusy, m_init); end
            vec++;
            if (qCount !== 4'(mq.size())) begin errs++; $display("FAIL rnd_qCount cyc %0d got %0d want %0d", n, qCount, mq.size()); end
            vec++;
            if (dropCnt !== 8'(m_drop)) begin errs++; $display("FAIL rnd_dropCnt cyc %0d got %0d want %0d", n, dropCnt, m_drop); end
            vec++;
            if (qOverflow !== e_ovf) begin errs++; $display("FAIL rnd_qOverflow cyc %0d got %b want %b", n, qOverflow, e_ovf); end
            for (int b = 0; b < 2; b++) begin
                vec++;
                if (wrEn[b] !== e_en[b] || (e_en[b] && (wrRow[b] !== 9'(e_row[b]) || wrVal[b] !== 2'(e_val[b])))) begin
                    errs++;
                    $display("FAIL rnd_bank%0d cyc %0d en=%b row=%0d val=%0d want en=%b row=%0d val=%0d",
                             b, n, wrEn[b], wrRow[b], wrVal[b], e_en[b], e_row[b], e_val[b]);
                end
            end
        end
        @(negedge clk);
        drive_idle();
        while (m_init != 0) @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        int found;
        int n;
        @(negedge clk);
        drive_idle();
        initStart = 1'b1;
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            if (initBusy === 1'b1 && wrRow[0] === 9'd200) found = 1;
        end
        vec++;
        if (found == 0) begin errs++; $display("FAIL midrst_reach_row200 row=%0d busy=%b", wrRow[0], initBusy); end
        rstN = 1'b0;
        #1;
        vec++;
        if (wrEn !== 2'b00 || initBusy !== 1'b1 || qCount !== 4'd0 || dropCnt !== 8'd0) begin
            errs++;
            $display("FAIL midrst_assert en=%b busy=%b q=%0d drop=%0d want en=00 busy=1 q=0 drop=0",
                     wrEn, initBusy, qCount, dropCnt);
        end
        @(negedge clk);
        rstN = 1'b1;
        #1;
        vec++;
        if (wrEn !== 2'b11 || wrRow[0] !== 9'd0 || wrRow[1] !== 9'd0) begin
            errs++; $display("FAIL midrst_restart en=%b rows=%0d/%0d want en=11 rows=0/0", wrEn, wrRow[0], wrRow[1]);
        end
        n = 0;
        while (initBusy === 1'b1 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        vec++;
        if (n != ROWS) begin errs++; $display("FAIL midrst_sweep_len got %0d cycles want %0d", n, ROWS); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_init_sweep();
        test_pair();
        test_conflict();
        test_fill_overflow();
        test_init_start();
        test_random();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d vectors", vec);
        $fatal(1, "timeout");
    end

endmodule
